srv_icb_arb2: RTL and testbench

//  Two-master to one-slave ICB arbiter with round-robin command arbitration and in-order response routing.

---
 rtl/srv_icb_arb2.sv | 157 +++++++++++++++
 tb/tb_srv_icb_arb2.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srv_icb_arb2.sv
// Two-master to one-slave ICB arbiter.
// Command arbitration is round-robin and adds no latency. A FIFO of grant IDs
// sends each slave response back to the master that issued the command.
module srv_icb_arb2 #(
  parameter int G_W_ADDR = 32,
  parameter int G_W_DATA = 32,
  parameter int G_OUTS   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  // master 0
  input  logic                  m0_cmd_valid,
  output logic                  m0_cmd_ready,
  input  logic [G_W_ADDR-1:0]   m0_cmd_addr,
  input  logic                  m0_cmd_read,
  input  logic [G_W_DATA-1:0]   m0_cmd_wdata,
  input  logic [G_W_DATA/8-1:0] m0_cmd_wmask,
  output logic                  m0_resp_valid,
  input  logic                  m0_resp_ready,
  output logic [G_W_DATA-1:0]   m0_resp_rdata,
  output logic                  m0_resp_err,
  // master 1
  input  logic                  m1_cmd_valid,
  output logic                  m1_cmd_ready,
  input  logic [G_W_ADDR-1:0]   m1_cmd_addr,
  input  logic                  m1_cmd_read,
  input  logic [G_W_DATA-1:0]   m1_cmd_wdata,
  input  logic [G_W_DATA/8-1:0] m1_cmd_wmask,
  output logic                  m1_resp_valid,
  input  logic                  m1_resp_ready,
  output logic [G_W_DATA-1:0]   m1_resp_rdata,
  output logic                  m1_resp_err,
  // shared slave
  output logic                  s_cmd_valid,
  input  logic                  s_cmd_ready,
  output logic [G_W_ADDR-1:0]   s_cmd_addr,
  output logic                  s_cmd_read,
  output logic [G_W_DATA-1:0]   s_cmd_wdata,
  output logic [G_W_DATA/8-1:0] s_cmd_wmask,
  input  logic                  s_resp_valid,
  output logic                  s_resp_ready,
  input  logic [G_W_DATA-1:0]   s_resp_rdata,
  input  logic                  s_resp_err
);

  localparam int W_CNT = $clog2(G_OUTS + 1);
  localparam int W_PTR = (G_OUTS > 1) ? $clog2(G_OUTS) : 1;
  localparam int DEPTH = 1 << W_PTR;

  logic             prio_q, prio_d;
  logic             lock_q, lock_d;
  logic             lock_id_q, lock_id_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic [W_PTR-1:0] rd_ptr_q, rd_ptr_d;
  logic [W_PTR-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] id_mem_q, id_mem_d;

  logic grant, full, empty, head, cmd_hs, resp_hs;

  function automatic logic [W_PTR-1:0] ptr_inc(input logic [W_PTR-1:0] p);
    return (p == W_PTR'(G_OUTS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == W_CNT'(G_OUTS));
  assign empty = (cnt_q == '0);
  assign head  = id_mem_q[rd_ptr_q];

  // Grant selection: a held lock wins, then a lone requester, then round-robin priority.
  always_comb begin
    if (lock_q)                            grant = lock_id_q;
    else if (m0_cmd_valid && !m1_cmd_valid) grant = 1'b0;
    else if (m1_cmd_valid && !m0_cmd_valid) grant = 1'b1;
    else                                   grant = prio_q;
  end

  // Command path: mux the granted master onto the slave; a full FIFO blocks everything.
  always_comb begin
    s_cmd_valid  = (grant ? m1_cmd_valid : m0_cmd_valid) & ~full;
    s_cmd_addr   = grant ? m1_cmd_addr  : m0_cmd_addr;
    s_cmd_read   = grant ? m1_cmd_read  : m0_cmd_read;
    s_cmd_wdata  = grant ? m1_cmd_wdata : m0_cmd_wdata;
    s_cmd_wmask  = grant ? m1_cmd_wmask : m0_cmd_wmask;
    m0_cmd_ready = ~grant & s_cmd_ready & ~full;
    m1_cmd_ready =  grant & s_cmd_ready & ~full;
    cmd_hs       = s_cmd_valid & s_cmd_ready;
  end

  // Response path: route to the master at the FIFO head; responses into an empty FIFO are dropped.
  always_comb begin
    m0_resp_valid = s_resp_valid & ~empty & ~head;
    m1_resp_valid = s_resp_valid & ~empty &  head;
    s_resp_ready  = (head ? m1_resp_ready : m0_resp_ready) & ~empty;
    m0_resp_rdata = s_resp_rdata;
    m1_resp_rdata = s_resp_rdata;
    m0_resp_err   = s_resp_err;
    m1_resp_err   = s_resp_err;
    resp_hs       = s_resp_valid & s_resp_ready;
  end

  // Next state for priority, lock and the grant-ID FIFO.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    prio_d    = prio_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    id_mem_d  = id_mem_q;

    if (cmd_hs) begin
      prio_d             = ~grant;
      lock_d             = 1'b0;
      wr_ptr_d           = ptr_inc(wr_ptr_q);
      id_mem_d[wr_ptr_q] = grant;
    end else if (s_cmd_valid && !s_cmd_ready) begin
      // Hold the grant until the slave takes the command it is already seeing.
      lock_d    = 1'b1;
      lock_id_d = grant;
    end

    if (resp_hs) rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({cmd_hs, resp_hs})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      prio_q    <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Grant-ID storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; cnt_q==0 marks every entry invalid.
    id_mem_q <= id_mem_d;
  end

endmodule

// File: tb/tb_srv_icb_arb2.sv
// Self-checking bench for srv_icb_arb2: directed scenarios followed by random traffic.
// A transaction-level model (queue of owner IDs, lock flag, priority bit) predicts every output.
module tb_srv_icb_arb2;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MW   = DW / 8;
  localparam int OUTS = 2;

  logic clk = 1'b0;
  logic reset;

  logic          mv[2];
  logic [AW-1:0] maddr[2];
  logic          mrd[2];
  logic [DW-1:0] mwd[2];
  logic [MW-1:0] mwm[2];
  logic          mrr[2];

  logic          m0_cmd_ready, m1_cmd_ready;
  logic          m0_resp_valid, m1_resp_valid;
  logic [DW-1:0] m0_resp_rdata, m1_resp_rdata;
  logic          m0_resp_err, m1_resp_err;

  logic          s_cmd_valid, s_cmd_ready;
  logic [AW-1:0] s_cmd_addr;
  logic          s_cmd_read;
  logic [DW-1:0] s_cmd_wdata;
  logic [MW-1:0] s_cmd_wmask;
  logic          s_resp_valid, s_resp_ready;
  logic [DW-1:0] s_resp_rdata;
  logic          s_resp_err;

  srv_icb_arb2 #(.G_W_ADDR(AW), .G_W_DATA(DW), .G_OUTS(OUTS)) dut (
    .clk(clk), .reset(reset),
    .m0_cmd_valid(mv[0]), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_addr(maddr[0]),
    .m0_cmd_read(mrd[0]), .m0_cmd_wdata(mwd[0]), .m0_cmd_wmask(mwm[0]),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(mrr[0]),
    .m0_resp_rdata(m0_resp_rdata), .m0_resp_err(m0_resp_err),
    .m1_cmd_valid(mv[1]), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_addr(maddr[1]),
    .m1_cmd_read(mrd[1]), .m1_cmd_wdata(mwd[1]), .m1_cmd_wmask(mwm[1]),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(mrr[1]),
    .m1_resp_rdata(m1_resp_rdata), .m1_resp_err(m1_resp_err),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_addr(s_cmd_addr),
    .s_cmd_read(s_cmd_read), .s_cmd_wdata(s_cmd_wdata), .s_cmd_wmask(s_cmd_wmask),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
    .s_resp_rdata(s_resp_rdata), .s_resp_err(s_resp_err)
  );

  always #5 clk = ~clk;

  // Reference model: IDs of outstanding commands in issue order, plus arbitration state.
  bit owners[$];
  bit m_lock, m_lock_id, m_prio;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; maddr[i] = '0; mrd[i] = 1'b0; mwd[i] = '0; mwm[i] = '0; mrr[i] = 1'b0;
    end
    s_cmd_ready = 1'b0; s_resp_valid = 1'b0; s_resp_rdata = '0; s_resp_err = 1'b0;
  endtask

  // Reset for one cycle; the model forgets everything outstanding.
  task automatic do_reset();
    reset = 1'b1;
    owners.delete();
    m_lock = 1'b0; m_lock_id = 1'b0; m_prio = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Inputs are set by the caller just after a falling edge. Check all outputs, clock once, update model.
  task automatic step(input string tag);
    bit full, empty, g, head, e_scv, e_srr, cmd_hs, resp_hs;
    #2;
    full  = (owners.size() == OUTS);
    empty = (owners.size() == 0);
    if (m_lock)              g = m_lock_id;
    else if (mv[0] && !mv[1]) g = 1'b0;
    else if (mv[1] && !mv[0]) g = 1'b1;
    else                     g = m_prio;
    e_scv = mv[g] && !full;
    head  = empty ? 1'b0 : owners[0];
    e_srr = !empty && mrr[head];

    check({tag, ".s_cmd_valid"},   s_cmd_valid,   e_scv);
    check({tag, ".m0_cmd_ready"},  m0_cmd_ready,  !g && s_cmd_ready && !full);
    check({tag, ".m1_cmd_ready"},  m1_cmd_ready,  g && s_cmd_ready && !full);
    check({tag, ".s_cmd_addr"},    s_cmd_addr,    maddr[g]);
    check({tag, ".s_cmd_read"},    s_cmd_read,    mrd[g]);
    check({tag, ".s_cmd_wdata"},   s_cmd_wdata,   mwd[g]);
    check({tag, ".s_cmd_wmask"},   s_cmd_wmask,   mwm[g]);
    check({tag, ".m0_resp_valid"}, m0_resp_valid, s_resp_valid && !empty && !head);
    check({tag, ".m1_resp_valid"}, m1_resp_valid, s_resp_valid && !empty && head);
    check({tag, ".s_resp_ready"},  s_resp_ready,  e_srr);
    check({tag, ".m0_resp_rdata"}, m0_resp_rdata, s_resp_rdata);
    check({tag, ".m1_resp_rdata"}, m1_resp_rdata, s_resp_rdata);
    check({tag, ".m0_resp_err"},   m0_resp_err,   s_resp_err);
    check({tag, ".m1_resp_err"},   m1_resp_err,   s_resp_err);

    cmd_hs  = e_scv && s_cmd_ready;
    resp_hs = s_resp_valid && e_srr;
    @(posedge clk);
    if (resp_hs) void'(owners.pop_front());
    if (cmd_hs) begin
      owners.push_back(g);
      m_prio = !g;
      m_lock = 1'b0;
    end else if (e_scv) begin
      m_lock    = 1'b1;
      m_lock_id = g;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);

    // Reset state: nothing outstanding, no responses forwarded, command valid follows masters.
    do_reset();
    mv[1] = 1'b1; maddr[1] = 32'h1111_0000; s_resp_valid = 1'b1;
    #1;
    check("rst.s_cmd_valid", s_cmd_valid, 1'b1);
    check("rst.s_resp_ready", s_resp_ready, 1'b0);
    step("rst");

    // 1: single read from m0, error response next cycle.
    do_reset(); idle();
    mv[0] = 1'b1; mrd[0] = 1'b1; maddr[0] = 32'hA000_0004; s_cmd_ready = 1'b1;
    #1;
    check("t1.m0_cmd_ready", m0_cmd_ready, 1'b1);
    check("t1.m1_resp_valid0", m1_resp_valid, 1'b0);
    step("t1a");
    idle();
    s_resp_valid = 1'b1; s_resp_err = 1'b1; s_resp_rdata = 32'hDEAD_BEEF; mrr[0] = 1'b1;
    #1;
    check("t1.m0_resp_valid", m0_resp_valid, 1'b1);
    check("t1.m0_resp_err", m0_resp_err, 1'b1);
    check("t1.m1_resp_valid1", m1_resp_valid, 1'b0);
    step("t1b");

    // 2: both masters streaming; grants alternate, responses follow issue order.
    do_reset(); idle();
    mv[0] = 1'b1; mv[1] = 1'b1; maddr[0] = 32'h0000_0100; maddr[1] = 32'h0000_0200;
    s_cmd_ready = 1'b1; s_resp_valid = 1'b1; mrr[0] = 1'b1; mrr[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t2.grant%0d.m0", i), m0_cmd_ready, (i % 2) == 0);
      check($sformatf("t2.grant%0d.m1", i), m1_cmd_ready, (i % 2) == 1);
      if (i == 0) check("t2.empty_drop", s_resp_ready, 1'b0);
      else        check($sformatf("t2.resp%0d.m1", i), m1_resp_valid, ((i - 1) % 2) == 1);
      step($sformatf("t2.%0d", i));
    end
    mv[0] = 1'b0; mv[1] = 1'b0;
    #1;
    check("t2.last_resp.m1", m1_resp_valid, 1'b1);
    step("t2.drain");

    // 3: slave stalls with both valid; m0 held, then m1 next.
    do_reset(); idle();
    mv[0] = 1'b1; mv[1] = 1'b1; maddr[0] = 32'h0000_A0A0; maddr[1] = 32'h0000_B1B1;
    mwd[0] = 32'h1234_5678; mwm[0] = 4'h3; mwd[1] = 32'h8765_4321; mwm[1] = 4'hC;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t3.stall%0d.addr", i), s_cmd_addr, 32'h0000_A0A0);
      step($sformatf("t3.s%0d", i));
    end
    s_cmd_ready = 1'b1;
    #1;
    check("t3.c4.addr", s_cmd_addr, 32'h0000_A0A0);
    check("t3.c4.m0_ready", m0_cmd_ready, 1'b1);
    step("t3.c4");
    #1;
    check("t3.c5.m1_ready", m1_cmd_ready, 1'b1);
    check("t3.c5.addr", s_cmd_addr, 32'h0000_B1B1);
    step("t3.c5");

    // 4: full FIFO blocks commands, even in the cycle a response pops.
    do_reset(); idle();
    mv[0] = 1'b1; s_cmd_ready = 1'b1;
    step("t4.a"); step("t4.b");
    mv[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("t4.full%0d.s_cmd_valid", i), s_cmd_valid, 1'b0);
      check($sformatf("t4.full%0d.m0_ready", i), m0_cmd_ready, 1'b0);
      check($sformatf("t4.full%0d.m1_ready", i), m1_cmd_ready, 1'b0);
      step($sformatf("t4.f%0d", i));
    end
    s_resp_valid = 1'b1; mrr[0] = 1'b1;
    #1;
    check("t4.pop.s_resp_ready", s_resp_ready, 1'b1);
    check("t4.pop.s_cmd_valid", s_cmd_valid, 1'b0);
    step("t4.pop");
    s_resp_valid = 1'b0;
    #1;
    check("t4.third.s_cmd_valid", s_cmd_valid, 1'b1);
    check("t4.third.m1_ready", m1_cmd_ready, 1'b1);
    step("t4.third");
    idle(); s_resp_valid = 1'b1; mrr[0] = 1'b1; mrr[1] = 1'b1;
    step("t4.d0"); step("t4.d1");

    // 5: outstanding IDs 1,0; head master stalls its response.
    do_reset(); idle();
    mv[1] = 1'b1; s_cmd_ready = 1'b1;
    step("t5.c1");
    mv[1] = 1'b0; mv[0] = 1'b1;
    step("t5.c0");
    idle();
    s_resp_valid = 1'b1; mrr[0] = 1'b1; mrr[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("t5.stall%0d.s_resp_ready", i), s_resp_ready, 1'b0);
      check($sformatf("t5.stall%0d.m1_valid", i), m1_resp_valid, 1'b1);
      check($sformatf("t5.stall%0d.m0_valid", i), m0_resp_valid, 1'b0);
      step($sformatf("t5.s%0d", i));
    end
    mrr[1] = 1'b1;
    #1;
    check("t5.r1.s_resp_ready", s_resp_ready, 1'b1);
    check("t5.r1.m0_valid", m0_resp_valid, 1'b0);
    step("t5.r1");
    #1;
    check("t5.r0.m0_valid", m0_resp_valid, 1'b1);
    check("t5.r0.m1_valid", m1_resp_valid, 1'b0);
    step("t5.r0");

    // 6: reset with two outstanding; later responses are dropped.
    do_reset(); idle();
    mv[0] = 1'b1; s_cmd_ready = 1'b1;
    step("t6.a"); step("t6.b");
    idle();
    s_resp_valid = 1'b1; mrr[0] = 1'b1; mrr[1] = 1'b1;
    do_reset();
    #1;
    check("t6.s_resp_ready", s_resp_ready, 1'b0);
    check("t6.m0_valid", m0_resp_valid, 1'b0);
    check("t6.m1_valid", m1_resp_valid, 1'b0);
    step("t6.drop");
    s_resp_valid = 1'b0; mv[0] = 1'b1; s_cmd_ready = 1'b1;
    #1;
    check("t6.cnt0_accept", m0_cmd_ready, 1'b1);
    step("t6.accept");

    // Random traffic against the model.
    idle();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 2; i++) begin
        mv[i]    = ($urandom_range(99, 0) < 65);
        maddr[i] = $urandom;
        mrd[i]   = 1'($urandom_range(1, 0));
        mwd[i]   = $urandom;
        mwm[i]   = 4'($urandom_range(15, 0));
        mrr[i]   = ($urandom_range(99, 0) < 70);
      end
      s_cmd_ready  = ($urandom_range(99, 0) < 60);
      s_resp_valid = ($urandom_range(99, 0) < 50);
      s_resp_rdata = $urandom;
      s_resp_err   = 1'($urandom_range(1, 0));
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
